// File: rtl/noc_pkg.sv
// noc_pkg: shared widths, packet layout and handshake state encoding for the NoC send bridge.
package noc_pkg;
  localparam int NOC_ADDR_W = 7;
  localparam int NOC_DATA_W = 32;
  localparam int NOC_PKT_W  = 2 * NOC_ADDR_W + NOC_DATA_W;
  typedef struct packed {
    logic [NOC_ADDR_W-1:0] src;
    logic [NOC_ADDR_W-1:0] dest;
    logic [NOC_DATA_W-1:0] payload;
  } pkt_t;
  typedef enum logic [1:0] {IDLE, PUSH, ACK} state_t;
endpackage

// File: rtl/noc_tx_fifo.sv
// noc_tx_fifo: first-word-fall-through packet queue with async reset.
//  clk, rst            clock, asynchronous active-high reset
//  wr_en, wr_data      push (ignored when full)
//  rd_en, rd_data      pop (ignored when empty); rd_data shows the head, 0 when empty
//  full, empty, count  occupancy status
module noc_tx_fifo #(
  parameter int W     = 46,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          wr, rd;
  // full/empty come from the registered count, so a same-cycle pop never frees a slot for a push
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign wr      = wr_en && !full;
  assign rd      = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
endmodule

// File: rtl/noc_tx_bridge.sv
// noc_tx_bridge: Nios PIO 4-phase send handshake to NoC valid/ready injection port.
//  clk, reset           clock, asynchronous active-high reset
//  send_addr, send_data [7]=req, [6:0]=dest; payload held while req=1
//  ack                  handshake acknowledge to Nios
//  noc_valid, noc_ready, noc_data  injection port, noc_data={src,dest,payload}
//  tx_level             packets queued
module noc_tx_bridge
  import noc_pkg::*;
#(
  parameter int NODE_ID    = 0,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    send_addr,
  input  logic [DATA_W-1:0]             send_data,
  output logic                          ack,
  output logic                          noc_valid,
  input  logic                          noc_ready,
  output logic [2*ADDR_W+DATA_W-1:0]    noc_data,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level
);
  logic [ADDR_W+DATA_W-1:0] hold;
  state_t                   state;
  logic                     full, empty, push, req;
  assign req       = send_addr[7];
  assign push      = state == PUSH && !full;
  assign noc_valid = !empty;
  // ACK is left only on req=0, so a held req can never re-enter IDLE and double-send
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ack   <= 1'b0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          hold  <= {send_addr[ADDR_W-1:0], send_data};
          state <= PUSH;
        end
        PUSH: if (!full) begin
          ack   <= 1'b1;
          state <= ACK;
        end
        ACK: if (!req) begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  noc_tx_fifo #(.W(2*ADDR_W+DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (push),
    .wr_data ({ADDR_W'(NODE_ID), hold}),
    .rd_en   (noc_ready),
    .rd_data (noc_data),
    .full    (full),
    .empty   (empty),
    .count   (tx_level)
  );
endmodule

// File: tb/tb_noc_tx_bridge.sv
// tb_noc_tx_bridge: directed checks of the NoC send bridge handshake, queueing and ordering.
module tb_noc_tx_bridge;
  localparam int NID = 7'h2A;
  logic        clk = 0, reset = 1;
  logic [7:0]  send_addr = 0;
  logic [31:0] send_data = 0;
  logic        ack, noc_valid, noc_ready = 0;
  logic [45:0] noc_data;
  logic [2:0]  tx_level;
  logic        rnd_en = 0;
  logic [45:0] rx [$];
  int total = 0, bad = 0;

  noc_tx_bridge #(.NODE_ID(NID)) dut (
    .clk(clk), .reset(reset), .send_addr(send_addr), .send_data(send_data), .ack(ack),
    .noc_valid(noc_valid), .noc_ready(noc_ready), .noc_data(noc_data), .tx_level(tx_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (noc_valid && noc_ready) rx.push_back(noc_data);

  always @(posedge clk) begin
    #2;
    if (rnd_en) noc_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (ack !== v && n < 60) begin
      step();
      n++;
    end
    chk(tag, 64'(ack), 64'(v));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (tx_level != 0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 64'(tx_level), 64'd0);
  endtask

  task automatic send(input logic [6:0] dest, input logic [31:0] d);
    send_addr = {1'b1, dest};
    send_data = d;
    wait_ack(1'b1, "send_ack_hi");
    send_addr = 8'h00;
    wait_ack(1'b0, "send_ack_lo");
  endtask

  function automatic logic [45:0] pkt(input logic [6:0] dest, input logic [31:0] d);
    return {7'(NID), dest, d};
  endfunction

  initial begin
    step(2);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_valid", 64'(noc_valid), 0);
    chk("rst_level", 64'(tx_level), 0);
    chk("rst_data", 64'(noc_data), 0);
    reset = 0;
    step(2);
    chk("idle_ack", 64'(ack), 0);
    chk("idle_valid", 64'(noc_valid), 0);

    // reset while in ACK
    send_addr = 8'h81;
    send_data = 32'h1111;
    wait_ack(1'b1, "mid_ack_hi");
    chk("mid_level", 64'(tx_level), 1);
    #1 reset = 1;
    #1 chk("mid_rst_ack", 64'(ack), 0);
    chk("mid_rst_level", 64'(tx_level), 0);
    send_addr = 8'h00;
    step();
    reset = 0;
    step(2);
    chk("mid_post_valid", 64'(noc_valid), 0);
    chk("mid_post_level", 64'(tx_level), 0);

    // single send, 2-cycle latency
    noc_ready = 1;
    rx.delete();
    send_addr = 8'h85;
    send_data = 32'hDEADBEEF;
    step();
    chk("s_ack_c1", 64'(ack), 0);
    chk("s_valid_c1", 64'(noc_valid), 0);
    step();
    chk("s_ack_c2", 64'(ack), 1);
    chk("s_valid_c2", 64'(noc_valid), 1);
    chk("s_data", 64'(noc_data), 64'(pkt(7'h05, 32'hDEADBEEF)));
    step();
    chk("s_valid_c3", 64'(noc_valid), 0);
    chk("s_ack_c3", 64'(ack), 1);
    send_addr = 8'h05;
    step();
    chk("s_ack_drop", 64'(ack), 0);
    chk("s_rx_n", 64'(rx.size()), 1);

    // backpressure
    noc_ready = 0;
    rx.delete();
    for (int i = 0; i < 4; i++) send(7'(i), 32'h100 + 32'(i));
    chk("bp_level4", 64'(tx_level), 4);
    chk("bp_head", 64'(noc_data), 64'(pkt(7'd0, 32'h100)));
    send_addr = 8'h84;
    send_data = 32'h104;
    step(4);
    chk("bp_stall_ack", 64'(ack), 0);
    chk("bp_stall_level", 64'(tx_level), 4);
    noc_ready = 1;
    step();
    chk("bp_pop_ack", 64'(ack), 0);
    chk("bp_pop_level", 64'(tx_level), 3);
    step();
    chk("bp_late_ack", 64'(ack), 1);
    send_addr = 8'h00;
    wait_ack(1'b0, "bp_ack_lo");
    drain("bp_drain");
    chk("bp_rx_n", 64'(rx.size()), 5);
    for (int i = 0; i < 5 && i < rx.size(); i++)
      chk("bp_order", 64'(rx[i]), 64'(pkt(7'(i), 32'h100 + 32'(i))));

    // ordering across pointer wrap with random backpressure
    rx.delete();
    rnd_en = 1;
    for (int i = 1; i <= 10; i++) send(7'h10, 32'(i));
    rnd_en = 0;
    #3 noc_ready = 1;
    drain("ord_drain");
    chk("ord_rx_n", 64'(rx.size()), 10);
    for (int i = 0; i < 10 && i < rx.size(); i++)
      chk("ord_payload", 64'(rx[i]), 64'(pkt(7'h10, 32'(i + 1))));

    // req dropped before ack
    rx.delete();
    step();
    send_addr = 8'h87;
    send_data = 32'hCAFE0005;
    step();
    send_addr = 8'h07;
    chk("early_ack_c1", 64'(ack), 0);
    step();
    chk("early_ack_c2", 64'(ack), 1);
    step();
    chk("early_ack_c3", 64'(ack), 0);
    step(5);
    chk("early_ack_idle", 64'(ack), 0);
    chk("early_rx_n", 64'(rx.size()), 1);
    if (rx.size() > 0) chk("early_data", 64'(rx[0]), 64'(pkt(7'h07, 32'hCAFE0005)));

    // req held long after ack
    rx.delete();
    send_addr = 8'h89;
    send_data = 32'h600D;
    wait_ack(1'b1, "held_ack_hi");
    step(20);
    chk("held_ack_still", 64'(ack), 1);
    chk("held_rx_mid", 64'(rx.size()), 1);
    send_addr = 8'h00;
    wait_ack(1'b0, "held_ack_lo");
    step(5);
    chk("held_rx_n", 64'(rx.size()), 1);
    chk("held_level", 64'(tx_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
